// File: rtl/cpu_fetch_sequencer.sv
// rtl/cpu_fetch_sequencer.sv - multi-cycle fetch/decode sequencer for the 6502-subset core
// Owns the PC, reads opcode/operand over a wait-stated port, resolves BNE locally.
package cpu_fetch_pkg;
  typedef enum logic [3:0] {
    OP_BRK = 4'd0,
    OP_NOP = 4'd1,
    OP_LDX = 4'd2,
    OP_INC = 4'd3,
    OP_BNE = 4'd4,
    OP_ORA = 4'd5,
    OP_AND = 4'd6,
    OP_EOR = 4'd7,
    OP_ADC = 4'd8,
    OP_STA = 4'd9,
    OP_LDA = 4'd10,
    OP_CMP = 4'd11,
    OP_SBC = 4'd12
  } opc_t;
endpackage

module cpu_fetch_sequencer
  import cpu_fetch_pkg::*;
#(
  parameter int unsigned        ADDR_W   = 9,
  parameter int unsigned        DATA_W   = 8,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              reset_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_rd_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ready_i,
  input  logic              zero_flag_i,
  output logic              exec_valid_o,
  output logic [3:0]        exec_op_o,
  output logic [DATA_W-1:0] exec_operand_o,
  input  logic              exec_ready_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              halted_o,
  output logic              illegal_o
);

  typedef enum logic [2:0] {
    S_RST0,
    S_FETCH,
    S_OPERAND,
    S_EXEC,
    S_HALT
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   pc_q;
  logic [ADDR_W-1:0]   pc_d;
  opc_t                op_q;
  logic [DATA_W-1:0]   operand_q;
  logic                mem_rd_q;
  logic                exec_valid_q;
  logic                halted_q;
  logic                illegal_q;

  opc_t                dec_op;
  logic                dec_has_opnd;
  logic                dec_illegal;
  logic signed [7:0]   br_off8;
  logic                mem_fire;

  // A ready with no request outstanding must never advance anything.
  assign mem_fire = mem_rd_q && mem_ready_i;
  assign br_off8  = operand_q[7:0];

  always_comb begin
    dec_op       = OP_NOP;
    dec_has_opnd = 1'b1;
    dec_illegal  = 1'b0;
    case (mem_rdata_i[7:0])
      8'h00: begin dec_op = OP_BRK; dec_has_opnd = 1'b0; end
      8'hEA: begin dec_op = OP_NOP; dec_has_opnd = 1'b0; end
      8'hA2: dec_op = OP_LDX;
      8'hE6: dec_op = OP_INC;
      8'hD0: dec_op = OP_BNE;
      8'h09: dec_op = OP_ORA;
      8'h29: dec_op = OP_AND;
      8'h49: dec_op = OP_EOR;
      8'h69: dec_op = OP_ADC;
      8'h85: dec_op = OP_STA;
      8'hA9: dec_op = OP_LDA;
      8'hC9: dec_op = OP_CMP;
      8'hE9: dec_op = OP_SBC;
      default: begin
        dec_op       = OP_NOP;
        dec_has_opnd = 1'b0;
        dec_illegal  = 1'b1;
      end
    endcase
  end

  // Branch offset is the low byte only, sign-extended and wrapped in ADDR_W bits.
  always_comb begin
    pc_d = pc_q;
    case (state_q)
      S_FETCH, S_OPERAND: begin
        if (mem_fire) pc_d = pc_q + ADDR_W'(1);
      end
      S_EXEC: begin
        if (op_q == OP_BNE && !zero_flag_i) pc_d = pc_q + ADDR_W'(br_off8);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= S_RST0;
      pc_q         <= RESET_PC;
      op_q         <= OP_NOP;
      operand_q    <= '0;
      mem_rd_q     <= 1'b0;
      exec_valid_q <= 1'b0;
      halted_q     <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      illegal_q <= 1'b0;
      case (state_q)
        S_RST0: begin
          state_q  <= S_FETCH;
          mem_rd_q <= 1'b1;
        end
        S_FETCH: begin
          if (mem_fire) begin
            op_q      <= dec_op;
            illegal_q <= dec_illegal;
            if (dec_has_opnd) begin
              state_q <= S_OPERAND;
            end else begin
              state_q      <= S_EXEC;
              mem_rd_q     <= 1'b0;
              operand_q    <= '0;
              exec_valid_q <= 1'b1;
            end
          end
        end
        S_OPERAND: begin
          if (mem_fire) begin
            operand_q    <= mem_rdata_i;
            mem_rd_q     <= 1'b0;
            state_q      <= S_EXEC;
            exec_valid_q <= (op_q != OP_BNE);
          end
        end
        S_EXEC: begin
          if (op_q == OP_BNE) begin
            state_q  <= S_FETCH;
            mem_rd_q <= 1'b1;
          end else if (exec_ready_i) begin
            exec_valid_q <= 1'b0;
            if (op_q == OP_BRK) begin
              state_q  <= S_HALT;
              halted_q <= 1'b1;
            end else begin
              state_q  <= S_FETCH;
              mem_rd_q <= 1'b1;
            end
          end
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          state_q      <= S_RST0;
          mem_rd_q     <= 1'b0;
          exec_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // The PC doubles as the read address in every state that issues a read.
  assign mem_addr_o     = pc_q;
  assign mem_rd_o       = mem_rd_q;
  assign exec_valid_o   = exec_valid_q;
  assign exec_op_o      = op_q;
  assign exec_operand_o = operand_q;
  assign pc_o           = pc_q;
  assign halted_o       = halted_q;
  assign illegal_o      = illegal_q;

endmodule
